// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state encoding and 50 MHz timing defaults
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int DEF_DEBOUNCE_CYC  = 500000;
   localparam int DEF_REPEAT_DELAY  = 25000000;
   localparam int DEF_REPEAT_PERIOD = 5000000;
   localparam int DEF_CNT_W         = 25;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser, debounce FSM and auto-repeat for one button
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_EN     = 1'b0,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             s1, s2;
   btn_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] rep, rep_next;
   logic             rep_first, rep_first_next;
   logic             level_next, pulse_next;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         rep       <= '0;
         rep_first <= 1'b0;
         btn_level <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         s1        <= btn_raw;
         s2        <= s1;
         state     <= state_next;
         cnt       <= cnt_next;
         rep       <= rep_next;
         rep_first <= rep_first_next;
         btn_level <= level_next;
         btn_pulse <= pulse_next;
      end
   end

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      rep_next       = rep;
      rep_first_next = rep_first;
      level_next     = btn_level;
      pulse_next     = 1'b0;
      case (state)
         IDLE: begin
            level_next = 1'b0;
            if (s2) begin
               state_next = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s2) begin
               state_next = IDLE;
            end else if (cnt == DB_LAST) begin
               state_next     = HELD;
               level_next     = 1'b1;
               pulse_next     = 1'b1;
               rep_next       = '0;
               rep_first_next = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         HELD: begin
            if (!s2) begin
               state_next = RELEASE_WAIT;
               cnt_next   = '0;
            end else if (REPEAT_EN) begin
               // first repeat waits the long delay, later ones the short period
               if (rep == (rep_first ? DLY_LAST : PER_LAST)) begin
                  pulse_next     = 1'b1;
                  rep_next       = '0;
                  rep_first_next = 1'b0;
               end else begin
                  rep_next = rep + 1'b1;
               end
            end
         end
         RELEASE_WAIT: begin
            if (s2) begin
               state_next = HELD;
               rep_next   = '0;
            end else if (cnt == DB_LAST) begin
               state_next = IDLE;
               level_next = 1'b0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - NBTN-channel button synchroniser, debouncer and press-pulse generator
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int               NBTN          = 2,
   parameter int               DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
   parameter int               REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int               REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter logic [NBTN-1:0]  REPEAT_MASK   = '0,
   parameter int               CNT_W         = DEF_CNT_W
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_pulse
);

   for (genvar i = 0; i < NBTN; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYC  (DEBOUNCE_CYC),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .REPEAT_EN     (REPEAT_MASK[i]),
         .CNT_W         (CNT_W)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .btn_pulse (btn_pulse[i])
      );
   end

endmodule
